// File: rtl/dot_requant_stage_if.sv
// Issue-side tags, tree sum/bias, and the requantized output stream of dot_requant_stage.
// The design connects through the slave modport; the issuing/consuming side uses master.
interface dot_requant_stage_if #(
    parameter int NBits = 12,
    parameter int ACC_W = 32
);
    logic                      issue_valid_in;
    logic                      issue_last_in;
    logic                      in_ready;
    logic signed [2*NBits-1:0] sum_in;
    logic signed [ACC_W-1:0]   bias_in;
    logic signed [NBits-1:0]   out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      overflow_err;

    modport master (
        output issue_valid_in, issue_last_in, sum_in, bias_in, out_ready,
        input  in_ready, out_data, out_valid, overflow_err
    );

    modport slave (
        input  issue_valid_in, issue_last_in, sum_in, bias_in, out_ready,
        output in_ready, out_data, out_valid, overflow_err
    );
endinterface

// File: rtl/dot_requant_stage.sv
// Aligns adder-tree sums with issue tags, accumulates chunks plus bias, requantizes
// to NBits and buffers results in a credit-protected output FIFO.
module dot_requant_stage #(
    parameter int NBits    = 12,
    parameter int TREE_LAT = 4,
    parameter int ACC_W    = 32,
    parameter int SHIFT    = 4,
    parameter int RELU     = 0,
    parameter int DEPTH    = 4
) (
    input logic clk_in,
    input logic rst_in,
    dot_requant_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + TREE_LAT + 2) + 1;
    localparam logic signed [ACC_W:0] RND =
        (SHIFT > 0) ? ((ACC_W+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (NBits - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    logic [TREE_LAT-1:0]     tag_valid;
    logic [TREE_LAT-1:0]     tag_last;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] sum_ext;
    logic                    first_chunk;
    logic                    stage_valid;
    logic signed [NBits-1:0] stage_data;
    logic signed [NBits-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             count;
    logic [CW-1:0]           inflight_last;
    logic                    ready;
    logic                    overflow;
    logic                    entry;
    logic                    tail_valid;
    logic                    tail_last;
    logic                    push;
    logic                    pop;
    logic signed [ACC_W:0]   rounded;
    logic signed [ACC_W:0]   shifted;
    logic signed [ACC_W:0]   clamped;
    logic signed [NBits-1:0] requant;

    // Every result not yet in the FIFO (delay line plus requant stage) holds a credit.
    always_comb begin
        inflight_last = CW'(stage_valid);
        for (int i = 0; i < TREE_LAT; i++) begin
            inflight_last = inflight_last + CW'(tag_valid[i] & tag_last[i]);
        end
        ready = (inflight_last + CW'(count)) < CW'(DEPTH);
    end

    assign entry      = bus.issue_valid_in & ready;
    assign tail_valid = tag_valid[TREE_LAT-1];
    assign tail_last  = tag_last[TREE_LAT-1];
    assign push       = stage_valid;
    assign pop        = (count != '0) & bus.out_ready;

    always_comb begin
        sum_ext  = ACC_W'(bus.sum_in);
        acc_next = (first_chunk ? bus.bias_in : acc) + sum_ext;
        rounded  = {acc_next[ACC_W-1], acc_next} + RND;
        shifted  = rounded >>> SHIFT;
        clamped  = shifted;
        if (RELU != 0 && shifted[ACC_W]) begin
            clamped = '0;
        end
        if (clamped > SAT_MAX) begin
            requant = SAT_MAX[NBits-1:0];
        end else if (clamped < SAT_MIN) begin
            requant = SAT_MIN[NBits-1:0];
        end else begin
            requant = clamped[NBits-1:0];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tag_valid   <= '0;
            tag_last    <= '0;
            acc         <= '0;
            first_chunk <= 1'b1;
            stage_valid <= 1'b0;
            stage_data  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
        end else begin
            tag_valid[0] <= entry;
            tag_last[0]  <= entry & bus.issue_last_in;
            for (int i = 1; i < TREE_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
            end
            if (bus.issue_valid_in && !ready) begin
                overflow <= 1'b1;
            end
            if (tail_valid) begin
                acc         <= acc_next;
                first_chunk <= tail_last;
            end
            stage_valid <= tail_valid & tail_last;
            if (tail_valid && tail_last) begin
                stage_data <= requant;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: the count gates everything read from it.
    always_ff @(posedge clk_in) begin
        if (!rst_in && push) begin
            mem[wr_ptr] <= stage_data;
        end
    end

    assign bus.in_ready     = ready;
    assign bus.out_valid    = (count != '0);
    assign bus.out_data     = (count != '0) ? mem[rd_ptr] : '0;
    assign bus.overflow_err = overflow;
endmodule

// File: tb/tb_dot_requant_stage.sv
// Directed bench for dot_requant_stage: a scoreboard queue of hand-computed results
// is drained by an independent monitor, plus direct checks of timing, credit and reset.
module tb_dot_requant_stage;
    localparam int NBits    = 12;
    localparam int TREE_LAT = 4;
    localparam int ACC_W    = 32;
    localparam int SHIFT    = 4;
    localparam int DEPTH    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dot_requant_stage_if #(.NBits(NBits), .ACC_W(ACC_W)) bus ();
    dot_requant_stage_if #(.NBits(NBits), .ACC_W(ACC_W)) relu_bus ();

    dot_requant_stage #(
        .NBits(NBits), .TREE_LAT(TREE_LAT), .ACC_W(ACC_W),
        .SHIFT(SHIFT), .RELU(0), .DEPTH(DEPTH)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus(bus)
    );

    dot_requant_stage #(
        .NBits(NBits), .TREE_LAT(TREE_LAT), .ACC_W(ACC_W),
        .SHIFT(SHIFT), .RELU(1), .DEPTH(DEPTH)
    ) dut_relu (
        .clk_in(clk),
        .rst_in(rst),
        .bus(relu_bus)
    );

    // Stand-in for the adder tree: whatever sum/bias is presented with an issue
    // emerges TREE_LAT cycles later.
    logic signed [2*NBits-1:0] stim_sum;
    logic signed [ACC_W-1:0]   stim_bias;
    logic signed [2*NBits-1:0] sum_dl  [TREE_LAT];
    logic signed [ACC_W-1:0]   bias_dl [TREE_LAT];

    always @(posedge clk) begin
        sum_dl[0]  <= stim_sum;
        bias_dl[0] <= stim_bias;
        for (int i = 1; i < TREE_LAT; i++) begin
            sum_dl[i]  <= sum_dl[i-1];
            bias_dl[i] <= bias_dl[i-1];
        end
    end

    assign bus.sum_in       = sum_dl[TREE_LAT-1];
    assign bus.bias_in      = bias_dl[TREE_LAT-1];
    assign relu_bus.sum_in  = sum_dl[TREE_LAT-1];
    assign relu_bus.bias_in = bias_dl[TREE_LAT-1];

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int exp_val;
    int issued;
    bit found;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic last, input int sum,
                                 input int bias, input bit expect_out, input int expected);
        @(negedge clk);
        bus.issue_valid_in = valid;
        bus.issue_last_in  = last;
        stim_sum           = (2*NBits)'(sum);
        stim_bias          = ACC_W'(bias);
        if (expect_out) exp_q.push_back(expected);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.issue_valid_in      = 1'b0;
            bus.issue_last_in       = 1'b0;
            relu_bus.issue_valid_in = 1'b0;
            relu_bus.issue_last_in  = 1'b0;
        end
    endtask

    task automatic waitRelu(input string name, input int expected);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            #1;
            if (relu_bus.out_valid) begin
                found = 1'b1;
                checkOutput(name, int'(relu_bus.out_data), expected);
            end
        end
        if (!found) checkOutput({name, "_timeout"}, 0, 1);
    endtask

    // Monitor: every accepted output is compared against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_output", int'(bus.out_data), 999999);
                end else begin
                    exp_val = exp_q.pop_front();
                    checkOutput("scoreboard", int'(bus.out_data), exp_val);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.issue_valid_in      = 1'b0;
        bus.issue_last_in       = 1'b0;
        bus.out_ready           = 1'b1;
        relu_bus.issue_valid_in = 1'b0;
        relu_bus.issue_last_in  = 1'b0;
        relu_bus.out_ready      = 1'b1;
        stim_sum  = '0;
        stim_bias = '0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("reset_out_data", int'(bus.out_data), 0);
        checkOutput("reset_in_ready", int'(bus.in_ready), 1);
        checkOutput("reset_overflow", int'(bus.overflow_err), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single chunk: (1000 + 8 + 8) >>> 4 = 63, visible six cycles after issue.
        applyStimulus(1'b1, 1'b1, 1000, 8, 1'b1, 63);
        idle(1);
        repeat (4) @(negedge clk);
        #1;
        checkOutput("latency_t5_low", int'(bus.out_valid), 0);
        @(negedge clk);
        #1;
        checkOutput("latency_t6_high", int'(bus.out_valid), 1);
        idle(6);

        // Saturation and negative rounding.
        applyStimulus(1'b1, 1'b1, 100000, 0, 1'b1, 2047);
        applyStimulus(1'b1, 1'b1, -1000, 0, 1'b1, -62);
        idle(10);

        // Three chunks then a fresh single chunk: 488 >>> 4 = 30, (32+16+8) >>> 4 = 3.
        applyStimulus(1'b1, 1'b0, 160, 0, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 160, 999, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 160, -555, 1'b1, 30);
        applyStimulus(1'b1, 1'b1, 32, 16, 1'b1, 3);
        idle(10);

        // Backpressure: four results fill the credit, a fifth issue must be refused.
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 1'b1, 160 * k, 0, 1'b1, 10 * k);
        end
        applyStimulus(1'b1, 1'b1, 800, 0, 1'b0, 0);
        #1;
        checkOutput("in_ready_full", int'(bus.in_ready), 0);
        idle(1);
        #1;
        checkOutput("overflow_set", int'(bus.overflow_err), 1);
        idle(8);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checkOutput("head_held_valid", int'(bus.out_valid), 1);
            checkOutput("head_held_data", int'(bus.out_data), 10);
            checkOutput("in_ready_held_low", int'(bus.in_ready), 0);
        end

        // Drain while refilling whenever credit is offered: results 50..55 in order.
        @(negedge clk);
        bus.out_ready = 1'b1;
        issued = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.in_ready && issued < 6) begin
                bus.issue_valid_in = 1'b1;
                bus.issue_last_in  = 1'b1;
                stim_sum  = (2*NBits)'(16 * (50 + issued));
                stim_bias = '0;
                exp_q.push_back(50 + issued);
                issued++;
            end else begin
                bus.issue_valid_in = 1'b0;
                bus.issue_last_in  = 1'b0;
            end
        end
        idle(12);
        checkOutput("stream_issued", issued, 6);

        // Reset with two results buffered and two still in flight.
        @(negedge clk);
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 160, 0, 1'b1, 10);
        applyStimulus(1'b1, 1'b1, 320, 0, 1'b1, 20);
        idle(8);
        applyStimulus(1'b1, 1'b1, 480, 0, 1'b1, 30);
        applyStimulus(1'b1, 1'b1, 640, 0, 1'b1, 40);
        idle(1);
        #1;
        checkOutput("overflow_sticky", int'(bus.overflow_err), 1);
        checkOutput("pre_reset_valid", int'(bus.out_valid), 1);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midreset_out_valid", int'(bus.out_valid), 0);
        checkOutput("midreset_out_data", int'(bus.out_data), 0);
        checkOutput("midreset_in_ready", int'(bus.in_ready), 1);
        checkOutput("midreset_overflow", int'(bus.overflow_err), 0);
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            checkOutput("no_stale_output", int'(bus.out_valid), 0);
        end

        // First chunk after reset uses its own bias.
        applyStimulus(1'b1, 1'b1, 1000, 8, 1'b1, 63);
        idle(10);

        // ReLU instance: negative clamps to zero, positive passes.
        @(negedge clk);
        relu_bus.issue_valid_in = 1'b1;
        relu_bus.issue_last_in  = 1'b1;
        stim_sum  = (2*NBits)'(-1000);
        stim_bias = '0;
        idle(1);
        waitRelu("relu_negative", 0);
        idle(4);
        @(negedge clk);
        relu_bus.issue_valid_in = 1'b1;
        relu_bus.issue_last_in  = 1'b1;
        stim_sum  = (2*NBits)'(1000);
        stim_bias = ACC_W'(8);
        idle(1);
        waitRelu("relu_positive", 63);

        idle(4);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
